// File: rtl/weighted_round_robin_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Holds the arbiter FSM state encoding and the weight-to-credit conversion.
package weighted_round_robin_arbiter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

    // Widest weight the conversion helper accepts; callers resize to their own width.
    localparam int MAX_WEIGHT_WIDTH = 16;

    // A zero weight still earns one beat, so a granted channel always makes progress.
    function automatic logic [MAX_WEIGHT_WIDTH-1:0] weight_to_credit(
        input logic [MAX_WEIGHT_WIDTH-1:0] weight
    );
        return (weight == '0) ? MAX_WEIGHT_WIDTH'(1) : weight;
    endfunction

endpackage

// File: rtl/rotating_priority_encoder.sv
// Cyclic first-one search: returns the first asserted request at or after
// pointer, wrapping past SIZE-1 back to channel 0.
module rotating_priority_encoder #(
    parameter int SIZE = 4,
    localparam int INDEX_WIDTH = $clog2(SIZE)
) (
    input  logic [SIZE-1:0]        requests,
    input  logic [INDEX_WIDTH-1:0] pointer,
    output logic [SIZE-1:0]        selected,
    output logic [INDEX_WIDTH-1:0] selected_index,
    output logic                   found
);

    logic [INDEX_WIDTH:0]   sum;
    logic [INDEX_WIDTH-1:0] candidate;

    always_comb begin
        selected       = '0;
        selected_index = '0;
        found          = 1'b0;
        sum            = '0;
        candidate      = '0;
        for (int offset = 0; offset < SIZE; offset++) begin
            // One extra bit keeps the wrap correct for non-power-of-two SIZE.
            sum = {1'b0, pointer} + (INDEX_WIDTH+1)'(offset);
            if (sum >= (INDEX_WIDTH+1)'(SIZE)) begin
                sum = sum - (INDEX_WIDTH+1)'(SIZE);
            end
            candidate = sum[INDEX_WIDTH-1:0];
            if (!found && requests[candidate]) begin
                found               = 1'b1;
                selected[candidate] = 1'b1;
                selected_index      = candidate;
            end
        end
    end

endmodule

// File: rtl/weighted_round_robin_arbiter.sv
// Registered weighted round-robin arbiter: each grant holds for up to `weight`
// accepted beats. Optional WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN adds a `lock` input.
module weighted_round_robin_arbiter
    import weighted_round_robin_arbiter_pkg::*;
#(
    parameter int SIZE         = 4,
    parameter int WEIGHT_WIDTH = 4,
    localparam int INDEX_WIDTH = $clog2(SIZE)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SIZE-1:0]              requests,
    input  logic [SIZE*WEIGHT_WIDTH-1:0] weights,
    input  logic                         grant_ready,
`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN
    input  logic                         lock,
`endif
    output logic [SIZE-1:0]              grant,
    output logic [INDEX_WIDTH-1:0]       grant_index,
    output logic                         grant_valid,
    output arb_state_t                   debug_state,
    output logic [WEIGHT_WIDTH-1:0]      debug_credit,
    output logic [INDEX_WIDTH-1:0]       debug_pointer
);

    // Handshake: a beat moves on a rising clock edge when grant_valid and
    // grant_ready are both high; grant_valid never waits on grant_ready.

    arb_state_t               state, state_next;
    logic [SIZE-1:0]          grant_next;
    logic [INDEX_WIDTH-1:0]   index_next;
    logic [WEIGHT_WIDTH-1:0]  credit, credit_next;
    logic [INDEX_WIDTH-1:0]   pointer, pointer_next;

    logic                     lock_active;
    logic                     rotate;
    logic [INDEX_WIDTH-1:0]   rotate_pointer;
    logic [SIZE-1:0]          other_requests;
    logic [SIZE-1:0]          search_requests;
    logic [INDEX_WIDTH-1:0]   search_pointer;
    logic [SIZE-1:0]          selected;
    logic [INDEX_WIDTH-1:0]   selected_index;
    logic                     found;
    logic [WEIGHT_WIDTH-1:0]  selected_weight;
    logic [WEIGHT_WIDTH-1:0]  load_credit;

`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN
    assign lock_active = lock;
`else
    assign lock_active = 1'b0;
`endif

    assign grant_valid   = |(grant & requests);
    assign debug_state   = state;
    assign debug_credit  = credit;
    assign debug_pointer = pointer;

    assign rotate_pointer = (grant_index == INDEX_WIDTH'(SIZE-1)) ? '0 : grant_index + 1'b1;

    // On rotation the current owner competes only when nobody else is asking.
    assign other_requests  = requests & ~grant;
    assign search_requests = (state == IDLE) ? requests :
                             (|other_requests) ? other_requests : requests;
    assign search_pointer  = (state == IDLE) ? pointer : rotate_pointer;

    rotating_priority_encoder #(
        .SIZE (SIZE)
    ) u_encoder (
        .requests       (search_requests),
        .pointer        (search_pointer),
        .selected       (selected),
        .selected_index (selected_index),
        .found          (found)
    );

    always_comb begin
        selected_weight = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (selected_index == INDEX_WIDTH'(i)) begin
                selected_weight = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
    end

    assign load_credit = WEIGHT_WIDTH'(weight_to_credit(MAX_WEIGHT_WIDTH'(selected_weight)));

    always_comb begin
        state_next   = state;
        grant_next   = grant;
        index_next   = grant_index;
        credit_next  = credit;
        pointer_next = pointer;
        rotate       = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    state_next  = GRANTED;
                    grant_next  = selected;
                    index_next  = selected_index;
                    credit_next = load_credit;
                end
            end
            GRANTED: begin
                if (!grant_valid) begin
                    rotate = 1'b1;
                end else if (grant_ready) begin
                    // Credit 0 here means a locked extension past the weight.
                    if (credit <= WEIGHT_WIDTH'(1)) begin
                        if (lock_active) begin
                            credit_next = '0;
                        end else begin
                            rotate = 1'b1;
                        end
                    end else begin
                        credit_next = credit - 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                index_next = '0;
            end
        endcase

        if (rotate) begin
            pointer_next = rotate_pointer;
            if (found) begin
                grant_next  = selected;
                index_next  = selected_index;
                credit_next = load_credit;
            end else begin
                state_next  = IDLE;
                grant_next  = '0;
                index_next  = '0;
                credit_next = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_index <= '0;
            credit      <= '0;
            pointer     <= '0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            grant_index <= index_next;
            credit      <= credit_next;
            pointer     <= pointer_next;
        end
    end

    // Structural invariants of the registered grant.
    assert property (@(posedge clock) disable iff (reset) $onehot0(grant));
    assert property (@(posedge clock) disable iff (reset) (state == IDLE) == (grant == '0));
    assert property (@(posedge clock) disable iff (reset)
                     (grant != '0) |-> grant[grant_index]);

endmodule

// File: tb/tb_weighted_round_robin_arbiter.sv
// Scoreboard bench for weighted_round_robin_arbiter (SIZE=4, WEIGHT_WIDTH=4).
// Define WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN to also exercise the lock feature.
module tb_weighted_round_robin_arbiter;
    import weighted_round_robin_arbiter_pkg::*;

    localparam int SIZE = 4;
    localparam int WW   = 4;
    localparam int IW   = 2;

    logic             clock;
    logic             reset;
    logic [SIZE-1:0]  requests;
    logic [SIZE*WW-1:0] weights;
    logic             grant_ready;
`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN
    logic             lock;
`endif
    logic [SIZE-1:0]  grant;
    logic [IW-1:0]    grant_index;
    logic             grant_valid;
    arb_state_t       debug_state;
    logic [WW-1:0]    debug_credit;
    logic [IW-1:0]    debug_pointer;

    weighted_round_robin_arbiter #(
        .SIZE         (SIZE),
        .WEIGHT_WIDTH (WW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .requests      (requests),
        .weights       (weights),
        .grant_ready   (grant_ready),
`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN
        .lock          (lock),
`endif
        .grant         (grant),
        .grant_index   (grant_index),
        .grant_valid   (grant_valid),
        .debug_state   (debug_state),
        .debug_credit  (debug_credit),
        .debug_pointer (debug_pointer)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard
    int total = 0;
    int bad   = 0;
    logic [SIZE-1:0] exp_q[$];

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [IW-1:0] onehot_to_index(input logic [SIZE-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (v[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    task automatic compare_output(input string tag);
        logic [SIZE-1:0] exp_grant;
        exp_grant = exp_q.pop_front();
        check_value({tag, "_grant"}, 32'(grant), 32'(exp_grant));
        check_value({tag, "_index"}, 32'(grant_index), 32'(onehot_to_index(exp_grant)));
        check_value({tag, "_valid"}, 32'(grant_valid), 32'(|(exp_grant & requests)));
    endtask

    // Drivers: inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic drive_cycle(input logic [SIZE-1:0] req, input logic ready,
                               input logic [SIZE-1:0] exp_grant, input string tag);
        requests    = req;
        grant_ready = ready;
        exp_q.push_back(exp_grant);
        @(posedge clock);
        #1;
        compare_output(tag);
    endtask

    task automatic apply_reset(input logic [SIZE-1:0] req, input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            drive_cycle(req, 1'b1, '0, "reset");
        end
        check_value("reset_state", 32'(debug_state), 32'(IDLE));
        check_value("reset_credit", 32'(debug_credit), 32'd0);
        check_value("reset_pointer", 32'(debug_pointer), 32'd0);
        reset = 1'b0;
    endtask

    function automatic logic [SIZE*WW-1:0] pack_weights(input int w0, input int w1,
                                                       input int w2, input int w3);
        return {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
    endfunction

    initial begin
        int beats[SIZE];
        logic [SIZE-1:0] exp_grant;
        reset       = 1'b1;
        requests    = '0;
        grant_ready = 1'b0;
        weights     = pack_weights(2, 2, 2, 2);
`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN
        lock        = 1'b0;
`endif
        #1;

        // Reset with all requests asserted, then fair rotation with weight 2.
        apply_reset(4'b1111, 3);
        check_value("post_reset_grant", 32'(grant), 32'd0);
        check_value("post_reset_valid", 32'(grant_valid), 32'd0);
        for (int k = 0; k < 64; k++) begin
            exp_grant = SIZE'(1) << ((k / 2) % 4);
            drive_cycle(4'b1111, 1'b1, exp_grant, "equal_weights");
        end

        // Uneven weights {3,0,1,4}: 9-cycle period, reset while channel busy.
        weights = pack_weights(3, 0, 1, 4);
        apply_reset(4'b0000, 1);
        for (int i = 0; i < SIZE; i++) beats[i] = 0;
        for (int k = 0; k < 900; k++) begin
            case (k % 9)
                0, 1, 2: exp_grant = 4'b0001;
                3:       exp_grant = 4'b0010;
                4:       exp_grant = 4'b0100;
                default: exp_grant = 4'b1000;
            endcase
            drive_cycle(4'b1111, 1'b1, exp_grant, "weighted");
            if (grant_valid && grant_ready) beats[grant_index]++;
        end
        check_value("beats_ch0", 32'(beats[0]), 32'd300);
        check_value("beats_ch1", 32'(beats[1]), 32'd100);
        check_value("beats_ch2", 32'(beats[2]), 32'd100);
        check_value("beats_ch3", 32'(beats[3]), 32'd400);

        // Channel 1 with weight 5 under a toggling ready: held 10 cycles.
        weights = pack_weights(1, 5, 1, 1);
        apply_reset(4'b1111, 1);
        drive_cycle(4'b0010, 1'b0, 4'b0010, "ready_load");
        check_value("ready_load_credit", 32'(debug_credit), 32'd5);
        for (int j = 0; j < 10; j++) begin
            exp_grant = (j < 9) ? 4'b0010 : 4'b0100;
            drive_cycle(4'b0110, 1'(j % 2), exp_grant, "ready_toggle");
            if (j < 9) check_value("ready_credit", 32'(debug_credit), 32'(5 - (j + 1) / 2));
        end

        // Request drop mid-grant rotates at once; no requests returns to IDLE.
        weights = pack_weights(1, 8, 1, 1);
        apply_reset(4'b0110, 2);
        drive_cycle(4'b0010, 1'b1, 4'b0010, "drop_load");
        drive_cycle(4'b0110, 1'b1, 4'b0010, "drop_beat");
        drive_cycle(4'b0110, 1'b1, 4'b0010, "drop_beat");
        check_value("drop_credit", 32'(debug_credit), 32'd6);
        drive_cycle(4'b0100, 1'b1, 4'b0100, "drop_rotate");
        check_value("drop_pointer", 32'(debug_pointer), 32'd2);
        drive_cycle(4'b0000, 1'b1, 4'b0000, "drop_idle");
        check_value("drop_state", 32'(debug_state), 32'(IDLE));

        // Lone requester with random ready keeps its grant across credit reloads.
        weights = pack_weights($urandom_range(0, 15), $urandom_range(0, 15),
                               $urandom_range(0, 15), $urandom_range(0, 3));
        apply_reset(4'b0000, 1);
        for (int k = 0; k < 40; k++) begin
            drive_cycle(4'b1000, 1'($urandom_range(0, 1)), 4'b1000, "single");
        end

`ifdef WEIGHTED_ROUND_ROBIN_ARBITER_LOCK_EN
        // Lock stretches a weight-2 grant to 6 beats; reset aborts a locked grant.
        weights = pack_weights(2, 2, 2, 2);
        apply_reset(4'b0000, 1);
        drive_cycle(4'b0011, 1'b1, 4'b0001, "lock_load");
        lock = 1'b1;
        for (int b = 0; b < 5; b++) begin
            drive_cycle(4'b0011, 1'b1, 4'b0001, "lock_hold");
        end
        check_value("lock_credit", 32'(debug_credit), 32'd0);
        lock = 1'b0;
        drive_cycle(4'b0011, 1'b1, 4'b0010, "lock_release");
        lock = 1'b1;
        drive_cycle(4'b0011, 1'b1, 4'b0010, "lock_again");
        drive_cycle(4'b0011, 1'b1, 4'b0010, "lock_again");
        reset = 1'b1;
        drive_cycle(4'b0011, 1'b1, 4'b0000, "lock_reset");
        reset = 1'b0;
        lock  = 1'b0;
`endif

        check_value("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
